// File: rtl/duart_rx_channel_if.sv
// Register-file side of one DUART receive channel:
// FIFO pop/clear strobes out, head character and status back.
interface duart_rx_channel_if;
  logic       rd_strb;
  logic       reset_err;
  logic       reset_rx;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       ffull;
  logic       overrun;
  logic       parity_err;
  logic       framing_err;
  logic       received_break;

  modport master (
    output rd_strb, reset_err, reset_rx,
    input  rx_data, rx_rdy, ffull, overrun,
    input  parity_err, framing_err, received_break
  );

  modport slave (
    input  rd_strb, reset_err, reset_rx,
    output rx_data, rx_rdy, ffull, overrun,
    output parity_err, framing_err, received_break
  );
endinterface

// File: rtl/duart_rx_channel.sv
// DUART receive channel: line synchroniser, character
// deserialiser with parity/framing/break checks, 3-deep FIFO.
module duart_rx_channel #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] bits_sel,
  input  logic       parity_en,
  input  logic       parity_odd,
  duart_rx_channel_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic          flush;
  logic          s1, s2, rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    nbits_m1;
  logic          pen, podd;
  logic [7:0]    shreg;
  logic          pbit;
  logic          is_brk;
  logic          pe_calc;
  logic          push_req;
  logic [10:0]   push_ent;

  logic [10:0]   mem [3];
  logic [1:0]    count;
  logic          do_pop, do_push;
  logic [1:0]    wr_idx;

  assign flush = reset | bus.reset_rx;
  assign rxs   = s2;

  // Two-flop synchroniser on the asynchronous line.
  always_ff @(posedge clk) begin
    if (flush) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
    end
  end

  // Character status evaluated at the stop-bit sample.
  always_comb begin
    is_brk  = (shreg == 8'h00) && !pbit && !rxs;
    pe_calc = pen & ((^shreg) ^ pbit ^ podd);
  end

  // Receive FSM: start validation, bit sampling, stop/break handling.
  always_ff @(posedge clk) begin
    if (flush) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      nbits_m1 <= '0;
      pen      <= 1'b0;
      podd     <= 1'b0;
      shreg    <= '0;
      pbit     <= 1'b0;
      push_req <= 1'b0;
      push_ent <= '0;
    end else begin
      push_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              idx      <= '0;
              shreg    <= '0;
              pbit     <= 1'b0;
              nbits_m1 <= {1'b0, bits_sel} + 3'd4;
              pen      <= parity_en;
              podd     <= parity_odd;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == nbits_m1) begin
              state <= pen ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            pbit  <= rxs;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            push_req <= 1'b1;
            if (is_brk) begin
              push_ent <= {3'b110, 8'h00};
              state    <= S_BREAK;
            end else begin
              push_ent <= {1'b0, !rxs, pe_calc, shreg};
              state    <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign do_pop  = bus.rd_strb && (count != 2'd0);
  assign do_push = push_req && ((count != 2'd3) || do_pop);
  assign wr_idx  = count - {1'b0, do_pop};

  // Shift FIFO with the head in slot 0; pop shifts before push lands.
  always_ff @(posedge clk) begin
    if (flush) begin
      count <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      if (do_pop) begin
        mem[0] <= mem[1];
        mem[1] <= mem[2];
      end
      for (int i = 0; i < 3; i++) begin
        if (do_push && wr_idx == 2'(i)) mem[i] <= push_ent;
      end
      count <= count - {1'b0, do_pop} + {1'b0, do_push};
    end
  end

  // Sticky overrun; an overflowing push beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.overrun <= 1'b0;
    end else if (!bus.reset_rx) begin
      if (push_req && count == 2'd3 && !do_pop) begin
        bus.overrun <= 1'b1;
      end else if (bus.reset_err) begin
        bus.overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_rdy         = (count != 2'd0);
  assign bus.ffull          = (count == 2'd3);
  assign bus.rx_data        = bus.rx_rdy ? mem[0][7:0] : 8'h00;
  assign bus.parity_err     = bus.rx_rdy & mem[0][8];
  assign bus.framing_err    = bus.rx_rdy & mem[0][9];
  assign bus.received_break = bus.rx_rdy & mem[0][10];

endmodule
